// File: rtl/lc3_regfile.sv
// lc3_regfile: 8 x WIDTH LC-3 register file with two combinational read
// ports, one write port, registered N/Z/P condition codes and a registered
// copy of the gated write strobe for trace.
// Optional feature: define REGFILE_BYPASS_EN to forward DR_IN onto a read
// port whose address matches DR during a write (suppressed while RST=1).

// One storage word; a bank of these forms the register array.
module lc3_reg_cell #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  // Reset clears the word; otherwise load on the per-register strobe.
  always_ff @(posedge CLK) begin
    if (RST)       q_q <= '0;
    else if (ld_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module lc3_regfile #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD_REG,
  input  logic [2:0]       DR,
  input  logic [WIDTH-1:0] DR_IN,
  input  logic             LD_CC,
  input  logic [2:0]       SR1,
  input  logic [2:0]       SR2,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  output logic [2:0]       CC,
  output logic [NREG-1:0]  WR_STB
);
  logic [NREG-1:0]            dec;
  logic [NREG-1:0]            ld_vec;
  logic [NREG-1:0][WIDTH-1:0] regs;
  logic [2:0]                 cc_d, cc_q;
  logic [NREG-1:0]            stb_q;

  // One-hot decode of the destination address.
  always_comb begin
    dec     = '0;
    dec[DR] = 1'b1;
  end

  assign ld_vec = dec & {NREG{LD_REG}};

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_reg
      lc3_reg_cell #(.WIDTH(WIDTH)) u_cell (
        .CLK  (CLK),
        .RST  (RST),
        .ld_i (ld_vec[g]),
        .d_i  (DR_IN),
        .q_o  (regs[g])
      );
    end
  endgenerate

  // Condition code from the sign/zero state of the write data.
  always_comb begin
    cc_d = 3'b001;
    if (DR_IN[WIDTH-1])    cc_d = 3'b100;
    else if (DR_IN == '0)  cc_d = 3'b010;
  end

  // CC loads independently of LD_REG; the strobe copy is refreshed every edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cc_q  <= 3'b010;
      stb_q <= '0;
    end else begin
      if (LD_CC) cc_q <= cc_d;
      stb_q <= ld_vec;
    end
  end

  assign CC     = cc_q;
  assign WR_STB = stb_q;

`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2;
  // Write-to-read forwarding per port; reset blocks it since the write is dropped.
  always_comb begin
    fwd1    = LD_REG && !RST && (SR1 == DR);
    fwd2    = LD_REG && !RST && (SR2 == DR);
    SR1_OUT = fwd1 ? DR_IN : regs[SR1];
    SR2_OUT = fwd2 ? DR_IN : regs[SR2];
  end
`else
  // Plain combinational reads; a same-cycle write shows up after the edge.
  always_comb begin
    SR1_OUT = regs[SR1];
    SR2_OUT = regs[SR2];
  end
`endif
endmodule
